// File: rtl/arm_register_file_if.sv
// Bus bundle between the decode/control unit and the ARMAria register file.
// Carries the write-back controls, the PC/SP/flag update inputs, the packed
// read-port addresses and every observable output of the register file.
//   master : control side, drives write-back and read addresses, sees outputs
//   slave  : register file side
interface arm_register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 16,
  parameter int READ_PORTS = 3,
  parameter int FLAG_COUNT = 4
);
  localparam int AW = $clog2(REG_COUNT);

  logic                           enable;
  logic                           mode;
  logic [2:0]                     wb_ctrl;
  logic [AW-1:0]                  wb_dst;
  logic [DATA_WIDTH-1:0]          wb_result;
  logic [DATA_WIDTH-1:0]          wb_mem;
  logic [DATA_WIDTH-1:0]          next_sp;
  logic [DATA_WIDTH-1:0]          next_pc;
  logic                           take_branch;
  logic [DATA_WIDTH-1:0]          branch_target;
  logic                           flags_we;
  logic [FLAG_COUNT-1:0]          flags_in;
  logic [READ_PORTS*AW-1:0]       rd_addr;
  logic [READ_PORTS*DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0]          pc;
  logic [DATA_WIDTH-1:0]          sp;
  logic [FLAG_COUNT-1:0]          flags;

  modport master (
    output enable, mode, wb_ctrl, wb_dst, wb_result, wb_mem, next_sp, next_pc,
           take_branch, branch_target, flags_we, flags_in, rd_addr,
    input  rd_data, pc, sp, flags
  );

  modport slave (
    input  enable, mode, wb_ctrl, wb_dst, wb_result, wb_mem, next_sp, next_pc,
           take_branch, branch_target, flags_we, flags_in, rd_addr,
    output rd_data, pc, sp, flags
  );
endinterface

// File: rtl/arm_register_file.sv
// Parametrised ARMAria register file: general registers, a mode-banked stack
// pointer, an integrated program counter with branch/link handling and a
// flags register. Written back from the ALU, load path and address handler.
// Ports:
//   slow_clock : processor clock, all state updates on the rising edge
//   reset      : synchronous active-high reset, overrides enable
//   bus        : arm_register_file_if.slave (write-back controls, read ports,
//                pc / sp / flags outputs)
module arm_register_file #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    REG_COUNT    = 16,
  parameter int                    READ_PORTS   = 3,
  parameter int                    SP_INDEX     = 13,
  parameter int                    LR_INDEX     = 14,
  parameter int                    PC_INDEX     = 15,
  parameter int                    FLAG_COUNT   = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(32'h0000_0000),
  parameter logic [DATA_WIDTH-1:0] RESET_SP_SYS = DATA_WIDTH'(32'h0000_FFFF),
  parameter logic [DATA_WIDTH-1:0] RESET_SP_USR = DATA_WIDTH'(32'h0000_7FFF),
  parameter bit                    BYPASS       = 1'b0
) (
  input logic                slow_clock,
  input logic                reset,
  arm_register_file_if.slave bus
);
  localparam int AW = $clog2(REG_COUNT);

  localparam logic [2:0] OP_ALU      = 3'd1;
  localparam logic [2:0] OP_LOAD     = 3'd2;
  localparam logic [2:0] OP_POP      = 3'd3;
  localparam logic [2:0] OP_PUSH     = 3'd4;
  localparam logic [2:0] OP_LINK     = 3'd5;
  localparam logic [2:0] OP_ALU_LINK = 3'd6;

  // SP_INDEX and PC_INDEX slots of regs_r are never written after reset; those
  // indices are served by the banked SP and pc_r instead.
  logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
  logic [DATA_WIDTH-1:0] pc_r;
  logic [DATA_WIDTH-1:0] sp_sys_r;
  logic [DATA_WIDTH-1:0] sp_usr_r;
  logic [FLAG_COUNT-1:0] flags_r;

  logic                  dst_write_s;
  logic                  sp_upd_s;
  logic                  lr_upd_s;
  logic [DATA_WIDTH-1:0] dst_data_s;
  logic [REG_COUNT-1:0]  gp_we_s;
  logic [DATA_WIDTH-1:0] gp_wdata_s [REG_COUNT];
  logic                  sp_we_s;
  logic [DATA_WIDTH-1:0] sp_wdata_s;
  logic [DATA_WIDTH-1:0] sp_cur_s;
  logic [DATA_WIDTH-1:0] pc_next_s;
  logic                  wr_live_s;
  logic [AW-1:0]         rd_idx_s;
  logic [DATA_WIDTH-1:0] rd_val_s;
  logic [READ_PORTS*DATA_WIDTH-1:0] rd_data_s;

  assign sp_cur_s  = bus.mode ? sp_usr_r : sp_sys_r;
  assign wr_live_s = bus.enable & ~reset;

  // Decode wb_ctrl into explicit-destination, SP-update and LR-update intents.
  always_comb begin
    dst_write_s = 1'b0;
    sp_upd_s    = 1'b0;
    lr_upd_s    = 1'b0;
    dst_data_s  = bus.wb_result;
    case (bus.wb_ctrl)
      OP_ALU:      dst_write_s = 1'b1;
      OP_LOAD:     begin dst_write_s = 1'b1; dst_data_s = bus.wb_mem; end
      OP_POP:      begin dst_write_s = 1'b1; dst_data_s = bus.wb_mem; sp_upd_s = 1'b1; end
      OP_PUSH:     sp_upd_s = 1'b1;
      OP_LINK:     lr_upd_s = 1'b1;
      OP_ALU_LINK: begin dst_write_s = 1'b1; lr_upd_s = 1'b1; end
      default:     dst_write_s = 1'b0;  // NONE and reserved code 7
    endcase
  end

  // Per-register write enables/data; explicit destination beats implicit LR.
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      gp_we_s[i]    = 1'b0;
      gp_wdata_s[i] = regs_r[i];
      if (i == SP_INDEX || i == PC_INDEX) begin
        gp_we_s[i] = 1'b0;
      end else if (dst_write_s && bus.wb_dst == AW'(i)) begin
        gp_we_s[i]    = 1'b1;
        gp_wdata_s[i] = dst_data_s;
      end else if (lr_upd_s && i == LR_INDEX) begin
        gp_we_s[i]    = 1'b1;
        gp_wdata_s[i] = bus.next_pc;
      end else begin
        gp_we_s[i] = 1'b0;
      end
    end
  end

  // Active-bank SP write (popped data beats next_sp) and PC priority select.
  always_comb begin
    sp_we_s    = 1'b0;
    sp_wdata_s = bus.next_sp;
    if (dst_write_s && bus.wb_dst == AW'(SP_INDEX)) begin
      sp_we_s    = 1'b1;
      sp_wdata_s = dst_data_s;
    end else if (sp_upd_s) begin
      sp_we_s = 1'b1;
    end else begin
      sp_we_s = 1'b0;
    end
    if (dst_write_s && bus.wb_dst == AW'(PC_INDEX)) begin
      pc_next_s = dst_data_s;
    end else if (bus.take_branch) begin
      pc_next_s = bus.branch_target;
    end else begin
      pc_next_s = bus.next_pc;
    end
  end

  // State update: reset first, then enabled write-back; mode picks the SP bank.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_r[i] <= '0;
      pc_r     <= RESET_PC;
      sp_sys_r <= RESET_SP_SYS;
      sp_usr_r <= RESET_SP_USR;
      flags_r  <= '0;
    end else if (bus.enable) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (gp_we_s[i]) regs_r[i] <= gp_wdata_s[i];
      end
      pc_r <= pc_next_s;
      if (sp_we_s) begin
        if (bus.mode) sp_usr_r <= sp_wdata_s;
        else          sp_sys_r <= sp_wdata_s;
      end
      if (bus.flags_we) flags_r <= bus.flags_in;
    end
  end

  // Combinational read ports; PC is never forwarded, SP/GP are when BYPASS.
  always_comb begin
    rd_data_s = '0;
    rd_idx_s  = '0;
    rd_val_s  = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_idx_s = bus.rd_addr[p*AW +: AW];
      if (rd_idx_s == AW'(PC_INDEX)) begin
        rd_val_s = pc_r;
      end else if (rd_idx_s == AW'(SP_INDEX)) begin
        rd_val_s = (BYPASS && wr_live_s && sp_we_s) ? sp_wdata_s : sp_cur_s;
      end else if (BYPASS && wr_live_s && gp_we_s[rd_idx_s]) begin
        rd_val_s = gp_wdata_s[rd_idx_s];
      end else begin
        rd_val_s = regs_r[rd_idx_s];
      end
      rd_data_s[p*DATA_WIDTH +: DATA_WIDTH] = rd_val_s;
    end
  end

  assign bus.rd_data = rd_data_s;
  assign bus.pc      = pc_r;
  assign bus.sp      = sp_cur_s;
  assign bus.flags   = flags_r;
endmodule

// File: tb/tb_arm_register_file.sv
// Self-checking bench for arm_register_file. Two instances share stimulus:
// dut0 without bypass, dut1 with bypass. A behavioural model holds the
// architectural state as plain arrays and applies the write-back rules.
module tb_arm_register_file;
  localparam int DW = 32;
  localparam int RC = 16;
  localparam int RP = 3;
  localparam int FC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arm_register_file_if #(.DATA_WIDTH(DW), .REG_COUNT(RC), .READ_PORTS(RP), .FLAG_COUNT(FC)) if0 ();
  arm_register_file_if #(.DATA_WIDTH(DW), .REG_COUNT(RC), .READ_PORTS(RP), .FLAG_COUNT(FC)) if1 ();

  assign if1.enable        = if0.enable;
  assign if1.mode          = if0.mode;
  assign if1.wb_ctrl       = if0.wb_ctrl;
  assign if1.wb_dst        = if0.wb_dst;
  assign if1.wb_result     = if0.wb_result;
  assign if1.wb_mem        = if0.wb_mem;
  assign if1.next_sp       = if0.next_sp;
  assign if1.next_pc       = if0.next_pc;
  assign if1.take_branch   = if0.take_branch;
  assign if1.branch_target = if0.branch_target;
  assign if1.flags_we      = if0.flags_we;
  assign if1.flags_in      = if0.flags_in;
  assign if1.rd_addr       = if0.rd_addr;

  arm_register_file #(.BYPASS(1'b0)) dut0 (.slow_clock(clk), .reset(rst), .bus(if0));
  arm_register_file #(.BYPASS(1'b1)) dut1 (.slow_clock(clk), .reset(rst), .bus(if1));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_regs [16];
  logic [31:0] m_sp [2];
  logic [31:0] m_pc;
  logic [3:0]  m_flags;
  logic [31:0] nx_regs [16];
  logic [31:0] nx_sp [2];
  logic [31:0] nx_pc;
  logic [3:0]  nx_flags;

  function automatic void model_compute();
    logic [2:0]  op;
    logic [31:0] v;
    nx_regs = m_regs; nx_sp = m_sp; nx_pc = m_pc; nx_flags = m_flags;
    if (rst) begin
      for (int i = 0; i < 16; i++) nx_regs[i] = 32'h0;
      nx_sp[0] = 32'h0000_FFFF; nx_sp[1] = 32'h0000_7FFF;
      nx_pc = 32'h0; nx_flags = 4'h0;
    end else if (if0.enable) begin
      op = if0.wb_ctrl;
      // implicit targets first; an explicit destination overrides them
      nx_pc = if0.take_branch ? if0.branch_target : if0.next_pc;
      if (op == 3'd3 || op == 3'd4) nx_sp[if0.mode] = if0.next_sp;
      if (op == 3'd5 || op == 3'd6) nx_regs[14] = if0.next_pc;
      if (op == 3'd1 || op == 3'd2 || op == 3'd3 || op == 3'd6) begin
        v = (op == 3'd2 || op == 3'd3) ? if0.wb_mem : if0.wb_result;
        if (if0.wb_dst == 4'd15)      nx_pc = v;
        else if (if0.wb_dst == 4'd13) nx_sp[if0.mode] = v;
        else                          nx_regs[if0.wb_dst] = v;
      end
      if (if0.flags_we) nx_flags = if0.flags_in;
    end
  endfunction

  function automatic logic [31:0] exp_rd(input logic [3:0] a, input bit byp);
    if (a == 4'd15) return m_pc;
    if (a == 4'd13) return byp ? nx_sp[if0.mode] : m_sp[if0.mode];
    return byp ? nx_regs[a] : m_regs[a];
  endfunction

  function automatic logic [31:0] rd0(input int p);
    return if0.rd_data[p*DW +: DW];
  endfunction

  function automatic logic [31:0] rd1(input int p);
    return if1.rd_data[p*DW +: DW];
  endfunction

  task automatic tick();
    model_compute();
    @(posedge clk); #1;
    m_regs = nx_regs; m_sp = nx_sp; m_pc = nx_pc; m_flags = nx_flags;
  endtask

  task automatic test_reset();
    rst = 1'b1; if0.enable = 1'b0; if0.mode = 1'b0; if0.wb_ctrl = 3'd0; if0.wb_dst = 4'd0;
    if0.wb_result = 32'h0; if0.wb_mem = 32'h0; if0.next_sp = 32'h0; if0.next_pc = 32'h0;
    if0.take_branch = 1'b0; if0.branch_target = 32'h0; if0.flags_we = 1'b0; if0.flags_in = 4'h0;
    if0.rd_addr = {4'd2, 4'd1, 4'd0};
    tick();
    rst = 1'b0; #1;
    n_cmp++; if (if0.pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", if0.pc, 32'h0); end
    n_cmp++; if (if0.sp !== 32'h0000_FFFF) begin n_err++; $display("FAIL reset_sp_sys: got %h want %h", if0.sp, 32'h0000_FFFF); end
    n_cmp++; if (if0.flags !== 4'h0) begin n_err++; $display("FAIL reset_flags: got %h want %h", if0.flags, 4'h0); end
    for (int p = 0; p < RP; p++) begin
      n_cmp++; if (rd0(p) !== 32'h0) begin n_err++; $display("FAIL reset_rd%0d: got %h want %h", p, rd0(p), 32'h0); end
    end
    if0.mode = 1'b1; if0.rd_addr = {4'd13, 4'd13, 4'd13}; #1;
    n_cmp++; if (if0.sp !== 32'h0000_7FFF) begin n_err++; $display("FAIL reset_sp_usr: got %h want %h", if0.sp, 32'h0000_7FFF); end
    n_cmp++; if (rd0(1) !== 32'h0000_7FFF) begin n_err++; $display("FAIL reset_rd_sp_usr: got %h want %h", rd0(1), 32'h0000_7FFF); end
  endtask

  task automatic test_alu();
    if0.enable = 1'b1; if0.mode = 1'b0; if0.wb_ctrl = 3'd1; if0.wb_dst = 4'd3;
    if0.wb_result = 32'hDEAD_BEEF; if0.next_pc = 32'h4; if0.rd_addr = {4'd15, 4'd13, 4'd3}; #1;
    n_cmp++; if (rd1(0) !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL alu_bypass: got %h want %h", rd1(0), 32'hDEAD_BEEF); end
    n_cmp++; if (rd0(0) !== 32'h0) begin n_err++; $display("FAIL alu_no_bypass: got %h want %h", rd0(0), 32'h0); end
    tick();
    if0.wb_ctrl = 3'd0; #1;
    n_cmp++; if (rd0(0) !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL alu_r3: got %h want %h", rd0(0), 32'hDEAD_BEEF); end
    n_cmp++; if (if0.pc !== 32'h4) begin n_err++; $display("FAIL alu_pc: got %h want %h", if0.pc, 32'h4); end
  endtask

  task automatic test_stack();
    if0.wb_ctrl = 3'd4; if0.mode = 1'b1; if0.next_sp = 32'h7FFB; if0.next_pc = 32'h8;
    tick();
    n_cmp++; if (if0.sp !== 32'h7FFB) begin n_err++; $display("FAIL push_sp_usr: got %h want %h", if0.sp, 32'h7FFB); end
    if0.wb_ctrl = 3'd3; if0.mode = 1'b0; if0.next_sp = 32'h1_0000; if0.wb_mem = 32'h55;
    if0.wb_dst = 4'd0; if0.next_pc = 32'hC; if0.rd_addr = {4'd15, 4'd13, 4'd0};
    tick();
    if0.wb_ctrl = 3'd0; #1;
    n_cmp++; if (if0.sp !== 32'h1_0000) begin n_err++; $display("FAIL pop_sp_sys: got %h want %h", if0.sp, 32'h1_0000); end
    n_cmp++; if (rd0(0) !== 32'h55) begin n_err++; $display("FAIL pop_r0: got %h want %h", rd0(0), 32'h55); end
    if0.mode = 1'b1; #1;
    n_cmp++; if (if0.sp !== 32'h7FFB) begin n_err++; $display("FAIL pop_usr_kept: got %h want %h", if0.sp, 32'h7FFB); end
    if0.mode = 1'b0;
  endtask

  task automatic test_link_branch();
    if0.wb_ctrl = 3'd5; if0.take_branch = 1'b1; if0.branch_target = 32'h200;
    if0.next_pc = 32'h104; if0.rd_addr = {4'd15, 4'd14, 4'd0};
    tick();
    n_cmp++; if (rd0(1) !== 32'h104) begin n_err++; $display("FAIL link_lr: got %h want %h", rd0(1), 32'h104); end
    n_cmp++; if (if0.pc !== 32'h200) begin n_err++; $display("FAIL link_pc: got %h want %h", if0.pc, 32'h200); end
    if0.wb_ctrl = 3'd1; if0.wb_dst = 4'd15; if0.wb_result = 32'h300;
    tick();
    n_cmp++; if (if0.pc !== 32'h300) begin n_err++; $display("FAIL alu_pc_prio: got %h want %h", if0.pc, 32'h300); end
    n_cmp++; if (rd0(2) !== 32'h300) begin n_err++; $display("FAIL rd_pc: got %h want %h", rd0(2), 32'h300); end
  endtask

  task automatic test_enable_freeze();
    logic [31:0] s_pc, s_sp, s_r2;
    logic [3:0]  s_fl;
    s_pc = m_pc; s_sp = m_sp[0]; s_r2 = m_regs[2]; s_fl = m_flags;
    if0.enable = 1'b0; if0.mode = 1'b0; if0.take_branch = 1'b1; if0.branch_target = 32'hABC;
    if0.flags_we = 1'b1; if0.flags_in = 4'hF; if0.wb_dst = 4'd2; if0.rd_addr = {4'd15, 4'd13, 4'd2};
    for (int k = 0; k < 3; k++) begin
      if0.wb_ctrl = (k == 1) ? 3'd4 : 3'd1;
      if0.wb_result = $urandom; if0.next_sp = $urandom;
      tick();
    end
    n_cmp++; if (if0.pc !== s_pc) begin n_err++; $display("FAIL freeze_pc: got %h want %h", if0.pc, s_pc); end
    n_cmp++; if (if0.sp !== s_sp) begin n_err++; $display("FAIL freeze_sp: got %h want %h", if0.sp, s_sp); end
    n_cmp++; if (if0.flags !== s_fl) begin n_err++; $display("FAIL freeze_flags: got %h want %h", if0.flags, s_fl); end
    n_cmp++; if (rd0(0) !== s_r2) begin n_err++; $display("FAIL freeze_r2: got %h want %h", rd0(0), s_r2); end
    rst = 1'b1;
    tick();
    rst = 1'b0; if0.rd_addr = {4'd15, 4'd13, 4'd0}; #1;
    n_cmp++; if (if0.pc !== 32'h0) begin n_err++; $display("FAIL rst_noen_pc: got %h want %h", if0.pc, 32'h0); end
    n_cmp++; if (if0.sp !== 32'h0000_FFFF) begin n_err++; $display("FAIL rst_noen_sp: got %h want %h", if0.sp, 32'h0000_FFFF); end
    n_cmp++; if (rd0(0) !== 32'h0) begin n_err++; $display("FAIL rst_noen_r0: got %h want %h", rd0(0), 32'h0); end
  endtask

  task automatic test_pop_sp_flags();
    if0.enable = 1'b1; if0.mode = 1'b0; if0.take_branch = 1'b0; if0.next_pc = 32'h10;
    if0.wb_ctrl = 3'd3; if0.wb_dst = 4'd13; if0.wb_mem = 32'h1234; if0.next_sp = 32'h9999;
    if0.flags_we = 1'b1; if0.flags_in = 4'b1010; if0.rd_addr = {4'd13, 4'd0, 4'd0}; #1;
    n_cmp++; if (rd1(2) !== 32'h1234) begin n_err++; $display("FAIL pop_sp_bypass: got %h want %h", rd1(2), 32'h1234); end
    n_cmp++; if (rd0(2) !== 32'hFFFF) begin n_err++; $display("FAIL pop_sp_old: got %h want %h", rd0(2), 32'hFFFF); end
    tick();
    if0.wb_ctrl = 3'd0; if0.flags_we = 1'b0; #1;
    n_cmp++; if (if0.sp !== 32'h1234) begin n_err++; $display("FAIL pop_sp_conflict: got %h want %h", if0.sp, 32'h1234); end
    n_cmp++; if (if0.flags !== 4'b1010) begin n_err++; $display("FAIL flags_load: got %b want %b", if0.flags, 4'b1010); end
    if0.mode = 1'b1; #1;
    n_cmp++; if (if0.sp !== 32'h7FFF) begin n_err++; $display("FAIL other_bank: got %h want %h", if0.sp, 32'h7FFF); end
  endtask

  task automatic test_random();
    logic [3:0] a;
    for (int it = 0; it < 300; it++) begin
      rst = ($urandom_range(0, 31) == 0);
      if0.enable = ($urandom_range(0, 7) != 0);
      if0.mode = 1'($urandom_range(0, 1));
      if0.wb_ctrl = 3'($urandom_range(0, 7));
      if0.wb_dst = 4'($urandom_range(0, 15));
      if0.wb_result = $urandom; if0.wb_mem = $urandom;
      if0.next_sp = $urandom; if0.next_pc = $urandom;
      if0.take_branch = 1'($urandom_range(0, 1)); if0.branch_target = $urandom;
      if0.flags_we = 1'($urandom_range(0, 1)); if0.flags_in = 4'($urandom_range(0, 15));
      if0.rd_addr = 12'($urandom);
      #1;
      model_compute();
      for (int p = 0; p < RP; p++) begin
        a = if0.rd_addr[p*4 +: 4];
        n_cmp++; if (rd0(p) !== exp_rd(a, 1'b0)) begin n_err++; $display("FAIL rnd_rd%0d it%0d idx%0d: got %h want %h", p, it, a, rd0(p), exp_rd(a, 1'b0)); end
        if (!rst) begin
          n_cmp++; if (rd1(p) !== exp_rd(a, 1'b1)) begin n_err++; $display("FAIL rnd_byp%0d it%0d idx%0d: got %h want %h", p, it, a, rd1(p), exp_rd(a, 1'b1)); end
        end
      end
      n_cmp++; if (if0.pc !== m_pc) begin n_err++; $display("FAIL rnd_pc it%0d: got %h want %h", it, if0.pc, m_pc); end
      n_cmp++; if (if0.sp !== m_sp[if0.mode]) begin n_err++; $display("FAIL rnd_sp it%0d: got %h want %h", it, if0.sp, m_sp[if0.mode]); end
      n_cmp++; if (if0.flags !== m_flags) begin n_err++; $display("FAIL rnd_flags it%0d: got %h want %h", it, if0.flags, m_flags); end
      n_cmp++; if (if1.pc !== m_pc) begin n_err++; $display("FAIL rnd_pc1 it%0d: got %h want %h", it, if1.pc, m_pc); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_stack();
    test_link_branch();
    test_enable_freeze();
    test_pop_sp_flags();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/arm_register_file.md
# arm_register_file

Parametrised register file for the ARMAria datapath, successor to the fixed 16×32 register bank. It provides a configurable number of registers and read ports, a stack pointer banked by processor mode, an integrated program counter with branch and link handling, and a flags register. It sits between the decode/control unit and the barrel shifter/ALU, and is written back from the ALU result, the load path and the memory address handler.

## Interface
- DATA_WIDTH, 32, register width in bits
- REG_COUNT, 16, architectural registers (power of two, ≥8); AW = log2(REG_COUNT)
- READ_PORTS, 3, independent combinational read ports (≥2)
- SP_INDEX, 13, index of the banked stack pointer
- LR_INDEX, 14, index of the link register
- PC_INDEX, 15, index of the program counter
- FLAG_COUNT, 4, width of the flags register (N,Z,C,V order, MSB first)
- RESET_PC, 0, PC value after reset
- RESET_SP_SYS, 0x0000_FFFF, system-mode SP after reset
- RESET_SP_USR, 0x0000_7FFF, user-mode SP after reset
- BYPASS, 0, 1 = same-cycle write data forwarded to read ports

- slow_clock  in  1  processor clock, all state on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  cycle-valid; 0 freezes all state
- mode  in  1  0 = system, 1 = user; selects SP bank
- wb_ctrl  in  3  write-back operation (see Operation)
- wb_dst  in  AW  destination register index
- wb_result  in  DATA_WIDTH  ALU result
- wb_mem  in  DATA_WIDTH  sign-extended load data
- next_sp  in  DATA_WIDTH  updated SP from address handler
- next_pc  in  DATA_WIDTH  sequential PC from address handler
- take_branch  in  1  load PC from branch_target
- branch_target  in  DATA_WIDTH  branch destination
- flags_we  in  1  load flags register
- flags_in  in  FLAG_COUNT  new flag values
- rd_addr  in  READ_PORTS*AW  packed read indices, port 0 in LSBs
- rd_data  out  READ_PORTS*DATA_WIDTH  packed read data, port 0 in LSBs
- pc  out  DATA_WIDTH  current PC
- sp  out  DATA_WIDTH  SP of the currently selected bank
- flags  out  FLAG_COUNT  current flags

## Operation
- wb_ctrl: 0 NONE; 1 ALU: R[wb_dst]←wb_result; 2 LOAD: R[wb_dst]←wb_mem; 3 POP: R[wb_dst]←wb_mem and SP←next_sp; 4 PUSH: SP←next_sp; 5 LINK: LR←next_pc; 6 ALU_LINK: R[wb_dst]←wb_result and LR←next_pc; 7 reserved, behaves as NONE.
- Any SP access (wb_dst == SP_INDEX, next_sp update, read of SP_INDEX, sp output) targets the bank selected by `mode`. The other bank is never touched.
- PC update on every enabled cycle, by priority: explicit write with wb_dst == PC_INDEX (ops 1, 2, 3, 6) > take_branch → branch_target > next_pc.
- Write conflicts on the same register:
  - POP with wb_dst == SP_INDEX: wb_mem wins over next_sp.
  - ALU_LINK with wb_dst == LR_INDEX: wb_result wins.
- flags ← flags_in when flags_we. Flags are independent of wb_ctrl.
- enable = 0: no register, PC, SP or flags change, regardless of other inputs.
- Reset:
  - all general registers and flags = 0
  - PC = RESET_PC
  - SP_sys = RESET_SP_SYS, SP_usr = RESET_SP_USR
  - reset overrides enable.
- Read ports are combinational from the register state.
  - Reading PC_INDEX returns pc.
  - Reading SP_INDEX returns the active-bank SP.
- BYPASS = 1: a read whose index matches a register being written this cycle returns the value that will be written. This covers wb_dst and the implicit SP and LR targets, with the conflict priorities above. PC is never bypassed.

## Timing
- Writes take effect at the rising edge; the new value is visible on rd_data, pc, sp and flags in the next cycle. Write latency is 1.
- Reads have zero latency (combinational). No read-port arbitration; all ports are fully independent, and duplicate indices are legal.
- `mode` is sampled at the edge for SP writes. Same-cycle reads use the current `mode`.
- A mode change with no write instantly switches the sp output to the other bank's stored value.
- Outputs immediately after reset: pc = RESET_PC, sp = RESET_SP_SYS if mode = 0, else RESET_SP_USR; flags = 0; rd_data = 0 for all general indices.

## Test plan
- Reset, then mode = 0 → pc = 0, sp = 0xFFFF, flags = 0. Switch mode to 1 → sp = 0x7FFF with no clock edge needed.
- ALU op with wb_dst = 3, wb_result = 0xDEAD_BEEF, next_pc = 4 → after one edge, rd port reading 3 = 0xDEADBEEF and pc = 4. With BYPASS = 1, the port shows 0xDEADBEEF in the same cycle.
- PUSH in mode 1 with next_sp = 0x7FFB, then POP in mode 0 with next_sp = 0x10000 and wb_mem = 0x55 into r0:
  - SP_usr = 0x7FFB
  - SP_sys = 0x10000
  - r0 = 0x55
- LINK with take_branch = 1, branch_target = 0x200, next_pc = 0x104 → LR = 0x104, pc = 0x200. Same cycle with ALU wb_dst = 15, wb_result = 0x300 → pc = 0x300.
- enable = 0 with ALU write, PUSH, flags_we = 1 and take_branch = 1 held for 3 cycles → no state changes. Assert reset with enable = 0 → reset values load.
- POP with wb_dst = SP_INDEX, wb_mem = 0x1234, next_sp = 0x9999 → active SP = 0x1234. flags_we with flags_in = 4'b1010 → flags = 1010 on the next cycle.
